// File: rtl/trigger_window_scheduler.sv
// trigger_window_scheduler: shares one acquisition window among N_CH stretched
// hit lines with round-robin arbitration. A window covers the hit duration plus
// a programmable extension and is followed by a programmable hold-off. Lengths
// are loaded through a valid/ready handshake that is accepted only while idle.
// Optional feature macro: TRIG_COUNTER_EN adds saturating TRIG_COUNT and
// DROP_COUNT outputs.
module trigger_window_scheduler #(
   parameter int N_CH                = 4,
   parameter int CH_ID_WIDTH         = 2,
   parameter int LEN_WIDTH           = 5,
   parameter int DEFAULT_EXTEND_LEN  = 4,
   parameter int DEFAULT_HOLDOFF_LEN = 2
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic                   CFG_VALID,
   output logic                   CFG_READY,
   input  logic [LEN_WIDTH-1:0]   CFG_EXTEND_LEN,
   input  logic [LEN_WIDTH-1:0]   CFG_HOLDOFF_LEN,
   input  logic [N_CH-1:0]        HIT_IN,
   output logic                   WINDOW_OUT,
   output logic [CH_ID_WIDTH-1:0] WINDOW_CH,
   output logic                   WINDOW_START,
   output logic                   WINDOW_END,
   output logic                   BUSY,
   output logic                   DROPPED
`ifdef TRIG_COUNTER_EN
   ,
   output logic [15:0]            TRIG_COUNT,
   output logic [15:0]            DROP_COUNT
`endif
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ACTIVE  = 2'd1,
      S_EXTEND  = 2'd2,
      S_HOLDOFF = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
   logic [CH_ID_WIDTH-1:0] ch_q, ch_d;
   logic [CH_ID_WIDTH-1:0] ptr_q, ptr_d;
   logic [LEN_WIDTH-1:0]   extend_len_q, extend_len_d;
   logic [LEN_WIDTH-1:0]   holdoff_len_q, holdoff_len_d;
   logic                   start_q, start_d;
   logic [N_CH-1:0]        hit_q;
   logic [N_CH-1:0]        hit_dly_q;

   logic                   grant_vld;
   logic [CH_ID_WIDTH-1:0] grant_ch;
   logic [CH_ID_WIDTH-1:0] cand;
   logic                   hit_cur;
   logic [N_CH-1:0]        own_mask;
   logic [N_CH-1:0]        rise;
   logic                   cfg_ready;
   logic                   extend_last;
   logic                   holdoff_last;

   // Round-robin search: first requester strictly after the last granted index
   always_comb begin
      grant_vld = 1'b0;
      grant_ch  = '0;
      cand      = '0;
      for (int i = 1; i <= N_CH; i++) begin
         cand = CH_ID_WIDTH'((int'(ptr_q) + i) % N_CH);
         if (!grant_vld && hit_q[cand]) begin
            grant_vld = 1'b1;
            grant_ch  = cand;
         end
      end
   end

   // Per-window decode: granted hit level, edge detect and terminal counts
   always_comb begin
      hit_cur      = hit_q[ch_q];
      own_mask     = N_CH'(1) << ch_q;
      rise         = hit_q & ~hit_dly_q;
      cfg_ready    = (state_q == S_IDLE) && !RESET;
      extend_last  = (cnt_q == extend_len_q - LEN_WIDTH'(1));
      holdoff_last = (cnt_q == holdoff_len_q - LEN_WIDTH'(1));
   end

   // Next-state logic, configuration capture and grant latching
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      ch_d          = ch_q;
      ptr_d         = ptr_q;
      extend_len_d  = extend_len_q;
      holdoff_len_d = holdoff_len_q;
      start_d       = 1'b0;

      if (CFG_VALID && cfg_ready) begin
         extend_len_d  = CFG_EXTEND_LEN;
         holdoff_len_d = CFG_HOLDOFF_LEN;
      end

      case (state_q)
         S_IDLE: begin
            if (grant_vld) begin
               ch_d    = grant_ch;
               ptr_d   = grant_ch;
               cnt_d   = '0;
               start_d = 1'b1;
               state_d = S_ACTIVE;
            end
         end
         S_ACTIVE: begin
            if (!hit_cur) begin
               cnt_d = '0;
               if (extend_len_q != '0) begin
                  state_d = S_EXTEND;
               end else if (holdoff_len_q != '0) begin
                  state_d = S_HOLDOFF;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_EXTEND: begin
            if (hit_cur) begin
               cnt_d   = '0;
               state_d = S_ACTIVE;
            end else if (extend_last) begin
               cnt_d   = '0;
               state_d = (holdoff_len_q != '0) ? S_HOLDOFF : S_IDLE;
            end else begin
               cnt_d = cnt_q + LEN_WIDTH'(1);
            end
         end
         S_HOLDOFF: begin
            if (holdoff_last) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + LEN_WIDTH'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output decode from registered state so pulses align with window cycles
   always_comb begin
      CFG_READY    = cfg_ready;
      WINDOW_OUT   = (state_q == S_ACTIVE) || (state_q == S_EXTEND);
      WINDOW_CH    = ch_q;
      WINDOW_START = start_q;
      WINDOW_END   = ((state_q == S_ACTIVE) && !hit_cur && (extend_len_q == '0)) ||
                     ((state_q == S_EXTEND) && !hit_cur && extend_last);
      BUSY         = (state_q != S_IDLE);
      DROPPED      = (state_q != S_IDLE) && (|(rise & ~own_mask));
   end

   // State, counters, configuration and two-stage hit sampling
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         ch_q          <= '0;
         ptr_q         <= CH_ID_WIDTH'(N_CH - 1);
         extend_len_q  <= LEN_WIDTH'(DEFAULT_EXTEND_LEN);
         holdoff_len_q <= LEN_WIDTH'(DEFAULT_HOLDOFF_LEN);
         start_q       <= 1'b0;
         hit_q         <= '0;
         hit_dly_q     <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         ch_q          <= ch_d;
         ptr_q         <= ptr_d;
         extend_len_q  <= extend_len_d;
         holdoff_len_q <= holdoff_len_d;
         start_q       <= start_d;
         hit_q         <= HIT_IN;
         hit_dly_q     <= hit_q;
      end
   end

`ifdef TRIG_COUNTER_EN
   logic [15:0] trig_cnt_q, trig_cnt_d;
   logic [15:0] drop_cnt_q, drop_cnt_d;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Event counters that stick at full scale instead of wrapping
   always_comb begin
      trig_cnt_d = WINDOW_START ? sat_inc16(trig_cnt_q) : trig_cnt_q;
      drop_cnt_d = DROPPED ? sat_inc16(drop_cnt_q) : drop_cnt_q;
      TRIG_COUNT = trig_cnt_q;
      DROP_COUNT = drop_cnt_q;
   end

   // Counter registers
   always_ff @(posedge CLK) begin
      if (RESET) begin
         trig_cnt_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         trig_cnt_q <= trig_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end
`endif

endmodule
